// File: rtl/arb16_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
package arb16_pkg;

    localparam int unsigned NUM_REQ = 16;
    localparam int unsigned IDX_W   = 4;

    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0]   req_idx_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Priority pointer after a release: one past the released master, 15 wraps to 0.
    function automatic req_idx_t next_ptr(input req_idx_t idx);
        return idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin pick: first set request at or after ptr (mod 16),
// returned one-hot plus encoded index, along with the OR of all requests.
module rr_pick16
    import arb16_pkg::*;
(
    input  logic [15:0] req,
    input  logic [3:0]  ptr,
    output logic [15:0] pick,
    output logic [3:0]  pick_idx,
    output logic        any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] shifted;
    req_vec_t             rot;
    req_idx_t             off;
    logic                 found;

    always_comb begin
        dbl     = {req, req};
        shifted = dbl >> ptr;
        rot     = shifted[NUM_REQ-1:0];
        found   = 1'b0;
        off     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                off   = req_idx_t'(i);
            end
        end
        // Offset is relative to ptr; 4-bit add rotates back to the absolute index.
        pick_idx = found ? req_idx_t'(off + ptr) : '0;
        pick     = found ? (req_vec_t'(1) << pick_idx) : '0;
    end

    assign any = |req;

endmodule

// File: rtl/rr_arbiter16.sv
// Sixteen-way round-robin arbiter with grant held until done.
// Optional ARB_LOCK_EN adds a lock input that suppresses release while high.
module rr_arbiter16
    import arb16_pkg::*;
#(
    parameter int unsigned PTR_INIT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] req,
    input  logic        done,
`ifdef ARB_LOCK_EN
    input  logic        lock,
`endif
    output logic        any_req,
    output logic [15:0] gnt,
    output logic        gnt_valid,
    output logic [3:0]  gnt_idx
);

    localparam req_idx_t PTR_RST = req_idx_t'(PTR_INIT);

    arb_state_e state_q, state_d;
    req_idx_t   ptr_q, ptr_d;
    req_vec_t   gnt_q, gnt_d;
    req_idx_t   gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;

    logic       release_now;
    req_idx_t   scan_ptr;
    req_vec_t   pick;
    req_idx_t   pick_idx;
    logic       pick_any;

`ifdef ARB_LOCK_EN
    assign release_now = (state_q == ARB_GRANT) && done && !lock;
`else
    assign release_now = (state_q == ARB_GRANT) && done;
`endif

    // The released master's successor takes priority in the same cycle, so the
    // picker sees the updated pointer before it is registered.
    assign scan_ptr = release_now ? next_ptr(gnt_idx_q) : ptr_q;

    rr_pick16 u_pick (
        .req      (req),
        .ptr      (scan_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_d       = pick;
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    state_d     = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (release_now) begin
                    ptr_d = scan_ptr;
                    if (pick_any) begin
                        gnt_d       = pick;
                        gnt_idx_d   = pick_idx;
                        gnt_valid_d = 1'b1;
                    end else begin
                        gnt_d       = '0;
                        gnt_idx_d   = '0;
                        gnt_valid_d = 1'b0;
                        state_d     = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= PTR_RST;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign any_req   = pick_any;
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: vector table, directed corner sequences,
// and randomized traffic against a scan-order reference model.
module tb_rr_arbiter16;

    logic        clk;
    logic        reset_n;
    logic [15:0] req;
    logic        done;
    logic        lock;
    logic        any_req;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic [3:0]  gnt_idx;

    int n_tests;
    int n_fail;

    // Reference model state
    int m_ptr;
    int m_idx;
    bit m_valid;

    rr_arbiter16 #(.PTR_INIT(0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .done      (done),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .any_req   (any_req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] req;
        logic        done;
        logic        exp_valid;
        int          exp_idx;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int scan(input logic [15:0] r, input int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    function automatic void model_edge(input logic [15:0] r, input logic d, input logic lk);
        bit lk_eff;
`ifdef ARB_LOCK_EN
        lk_eff = lk;
`else
        lk_eff = 1'b0;
`endif
        if (!m_valid) begin
            if (r != 16'h0) begin
                m_idx   = scan(r, m_ptr);
                m_valid = 1'b1;
            end
        end else if (d && !lk_eff) begin
            m_ptr = (m_idx + 1) % 16;
            if (r != 16'h0) m_idx = scan(r, m_ptr);
            else begin
                m_valid = 1'b0;
                m_idx   = 0;
            end
        end
    endfunction

    task automatic check_model(input string name);
        logic [15:0] exp_gnt;
        exp_gnt = m_valid ? (16'h1 << m_idx) : 16'h0;
        check({name, ".gnt"},       gnt,       exp_gnt);
        check({name, ".gnt_valid"}, gnt_valid, m_valid);
        check({name, ".gnt_idx"},   gnt_idx,   m_idx);
    endtask

    // Advance one clock with current inputs; model follows the same edge.
    task automatic step();
        model_edge(req, done, lock);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        lock    = 1'b0;
        m_ptr   = 0;
        m_idx   = 0;
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{16'h0000, 1'b0, 1'b0, 0};
        vecs[1]  = '{16'h0001, 1'b0, 1'b1, 0};
        vecs[2]  = '{16'h0001, 1'b0, 1'b1, 0};
        vecs[3]  = '{16'h0000, 1'b0, 1'b1, 0};
        vecs[4]  = '{16'h0000, 1'b1, 1'b0, 0};
        vecs[5]  = '{16'h0003, 1'b0, 1'b1, 1};
        vecs[6]  = '{16'h0003, 1'b1, 1'b1, 0};
        vecs[7]  = '{16'h0003, 1'b1, 1'b1, 1};
        vecs[8]  = '{16'h0002, 1'b1, 1'b1, 1};
        vecs[9]  = '{16'h8000, 1'b0, 1'b1, 1};
        vecs[10] = '{16'h8000, 1'b1, 1'b1, 15};
        vecs[11] = '{16'h8001, 1'b1, 1'b1, 0};
        vecs[12] = '{16'h0000, 1'b1, 1'b0, 0};
        vecs[13] = '{16'h0000, 1'b1, 1'b0, 0};
        vecs[14] = '{16'h0001, 1'b0, 1'b1, 0};

        // Reset state with idle requests
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check("reset.gnt", gnt, 16'h0);
        check("reset.gnt_valid", gnt_valid, 1'b0);
        check("reset.gnt_idx", gnt_idx, 0);
        check("reset.any_req", any_req, 1'b0);

        // Vector table from reset
        do_reset();
        for (int i = 0; i < 15; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            #1;
            check($sformatf("vec%0d.any_req", i), any_req, |vecs[i].req);
            step();
            check($sformatf("vec%0d.gnt_valid", i), gnt_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d.gnt_idx", i), gnt_idx, vecs[i].exp_idx);
            check($sformatf("vec%0d.gnt", i), gnt,
                  vecs[i].exp_valid ? (16'h1 << vecs[i].exp_idx) : 16'h0);
        end
        done = 1'b0;

        // All requesting, done every cycle: indices 0..15,0 with no bubble
        do_reset();
        req = 16'hFFFF;
        step();
        check("ffff.first", gnt_idx, 0);
        done = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("ffff.idx%0d", k), gnt_idx, (k + 1) % 16);
            check($sformatf("ffff.valid%0d", k), gnt_valid, 1'b1);
        end
        done = 1'b0;

        // Pointer wrap: release idx 14 -> ptr 15 -> req 0011 picks 0, then 4
        do_reset();
        req = 16'h4000;
        step();
        check("wrap.g14", gnt_idx, 14);
        req  = 16'h0011;
        done = 1'b1;
        step();
        check("wrap.g0", gnt_idx, 0);
        step();
        check("wrap.g4", gnt_idx, 4);
        check("wrap.gnt4", gnt, 16'h0010);
        done = 1'b0;

        // Granted master drops req without done; then async reset mid-grant
        do_reset();
        req = 16'h0010;
        step();
        check("hold.g4", gnt, 16'h0010);
        req = 16'h0200;
        for (int k = 0; k < 3; k++) step();
        check("hold.still4", gnt, 16'h0010);
        check("hold.valid", gnt_valid, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async.gnt", gnt, 16'h0);
        check("async.valid", gnt_valid, 1'b0);
        check("async.idx", gnt_idx, 0);
        do_reset();

`ifdef ARB_LOCK_EN
        req = 16'h0024;
        step();
        check("lock.g2", gnt_idx, 2);
        lock = 1'b1;
        done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("lock.hold%0d", k), gnt, 16'h0004);
        end
        lock = 1'b0;
        step();
        check("lock.release", gnt_idx, 5);
        done = 1'b0;
        do_reset();
`endif

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0: req = '0;
                1: req = 16'h1 << $urandom_range(0, 15);
                2: req = 16'($urandom) & 16'($urandom);
                default: req = 16'($urandom);
            endcase
            done = ($urandom_range(0, 2) != 0);
            lock = ($urandom_range(0, 3) == 0);
            #1;
            check("rand.any_req", any_req, |req);
            step();
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
